// File: rtl/os_array_sequencer.sv
// Sequencer for the output-stationary systolic array: skewed operand feeds,
// pipeline flush wait, then row-by-row result drain under valid/ready.

module os_seq_skew_lane #(
   parameter int IDX = 0,
   parameter int TW  = 8,
   parameter int KW  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          feed,
   input  logic [TW-1:0] t,
   input  logic [KW-1:0] k,
   output logic          en,
   output logic          first
);
   // rel = t - IDX; its top bit flags t < IDX without an unsigned compare.
   logic [TW:0] rel;
   logic        en_d;
   logic        first_d;

   assign rel     = {1'b0, t} - (TW+1)'(IDX);
   assign en_d    = feed && !rel[TW] && (rel[TW-1:0] < TW'(k));
   assign first_d = feed && (rel == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en    <= 1'b0;
         first <= 1'b0;
      end else begin
         en    <= en_d;
         first <= first_d;
      end
   end
endmodule

module os_array_sequencer #(
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int KW      = 16,
   parameter int MAC_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [KW-1:0]           k_len,
   output logic                    busy,
   output logic [ROWS-1:0]         a_en,
   output logic [ROWS-1:0]         a_first,
   output logic [COLS-1:0]         b_en,
   output logic [COLS-1:0]         b_first,
   output logic                    drain_valid,
   input  logic                    drain_ready,
   output logic [$clog2(ROWS)-1:0] drain_row,
   output logic                    done
);
   localparam int RW    = $clog2(ROWS);
   localparam int TW    = KW + $clog2(ROWS + COLS + MAC_LAT) + 1;
   localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FEED  = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state, nxt_state;
   logic [TW-1:0] t, nxt_t;
   logic [KW-1:0] k_q, nxt_k;
   logic [RW-1:0] nxt_row;
   logic          accept;
   logic          feed_last;
   logic          flush_last;
   logic          row_acc;
   logic          last_row;
   logic          lane_feed;

   assign accept     = (state == S_IDLE) && start && (k_len != '0);
   assign feed_last  = (t == TW'(k_q) + TW'(MAXRC - 2));
   assign flush_last = (t == TW'(k_q) + TW'(ROWS + COLS - 3 + MAC_LAT));
   assign row_acc    = (state == S_DRAIN) && drain_ready;
   assign last_row   = (drain_row == RW'(ROWS - 1));
   assign nxt_k      = accept ? k_len : k_q;

   always_comb begin
      nxt_state = state;
      case (state)
         S_IDLE:  if (accept) nxt_state = S_FEED;
         S_FEED:  if (feed_last) nxt_state = S_FLUSH;
         S_FLUSH: if (flush_last) nxt_state = S_DRAIN;
         S_DRAIN: if (row_acc && last_row) nxt_state = S_DONE;
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      nxt_t = t;
      if (state == S_IDLE)
         nxt_t = '0;
      else if ((state == S_FEED) || (state == S_FLUSH))
         nxt_t = t + TW'(1);
   end

   always_comb begin
      nxt_row = drain_row;
      if (row_acc)
         nxt_row = last_row ? '0 : drain_row + RW'(1);
   end

   // Outputs are registered from next-state values so they line up with state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         t           <= '0;
         k_q         <= '0;
         drain_row   <= '0;
         busy        <= 1'b0;
         drain_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= nxt_state;
         t           <= nxt_t;
         k_q         <= nxt_k;
         drain_row   <= nxt_row;
         busy        <= (nxt_state == S_FEED) || (nxt_state == S_FLUSH) ||
                        (nxt_state == S_DRAIN);
         drain_valid <= (nxt_state == S_DRAIN);
         done        <= (nxt_state == S_DONE);
      end
   end

   assign lane_feed = (nxt_state == S_FEED);

   for (genvar r = 0; r < ROWS; r++) begin : g_a
      os_seq_skew_lane #(.IDX(r), .TW(TW), .KW(KW)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .feed  (lane_feed),
         .t     (nxt_t),
         .k     (nxt_k),
         .en    (a_en[r]),
         .first (a_first[r])
      );
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b
      os_seq_skew_lane #(.IDX(c), .TW(TW), .KW(KW)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .feed  (lane_feed),
         .t     (nxt_t),
         .k     (nxt_k),
         .en    (b_en[c]),
         .first (b_first[c])
      );
   end
endmodule
